// File: rtl/elevator_scan_controller.sv
// elevator_scan_controller
//   N-floor elevator car controller. Floor calls are latched into a sticky
//   bitmask and served in SCAN order: the car keeps its travel direction while
//   any request lies ahead and reverses only when the side ahead is empty.
//   Each one-floor move takes MOVE_TICKS cycles. The door stays open for
//   DOOR_TICKS cycles, and that dwell restarts whenever the current floor is
//   called again while the door is open.
//
// Ports
//   clk            clock, all state updates on the rising edge
//   rst_n          synchronous reset, active HIGH (1 = reset)
//   call_in        per-floor call request, latched on any cycle a bit is 1
//   current_floor  floor the car is at
//   pending        latched outstanding requests
//   door_open      1 while dwelling with the door open
//   moving         1 while travelling up or down
//   dir_up         current or last travel direction (1 = up)
//   idle           1 while parked with nothing to do
//
// Every output is a register or is decoded from registered state. There is no
// combinational path from call_in to any output.
module elevator_scan_controller #(
  parameter int N_FLOORS   = 8,
  parameter int FLOOR_W    = 4,
  parameter int MOVE_TICKS = 10,
  parameter int DOOR_TICKS = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_FLOORS-1:0] call_in,
  output logic [FLOOR_W-1:0]  current_floor,
  output logic [N_FLOORS-1:0] pending,
  output logic                door_open,
  output logic                moving,
  output logic                dir_up,
  output logic                idle
);

  localparam int MAX_TICKS = (MOVE_TICKS > DOOR_TICKS) ? MOVE_TICKS : DOOR_TICKS;
  localparam int TIMER_W   = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
  localparam logic [TIMER_W-1:0] MOVE_LAST = TIMER_W'(MOVE_TICKS - 1);
  localparam logic [TIMER_W-1:0] DOOR_LAST = TIMER_W'(DOOR_TICKS - 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(N_FLOORS - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MOVE_UP = 2'd1,
    S_MOVE_DN = 2'd2,
    S_DOOR    = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [FLOOR_W-1:0]    floor_q, floor_d;
  logic [N_FLOORS-1:0]   pending_q, pending_d;
  logic                  dir_q, dir_d;
  logic [TIMER_W-1:0]    timer_q, timer_d;

  logic [N_FLOORS-1:0]   eff;
  logic [N_FLOORS-1:0]   floor_oh;
  logic [N_FLOORS-1:0]   up_oh;
  logic [N_FLOORS-1:0]   dn_oh;
  logic [N_FLOORS-1:0]   serve_mask;
  logic                  ahead_up;
  logic                  ahead_dn;
  logic                  ahead_same;
  logic                  ahead_back;
  logic                  here_call;
  state_t                depart_state;
  logic                  depart_dir;

  // Request view and SCAN direction analysis.
  // eff includes this cycle's calls, so a new call is seen on the same edge it arrives.
  always_comb begin
    eff      = pending_q | call_in;
    floor_oh = '0;
    ahead_up = 1'b0;
    ahead_dn = 1'b0;
    for (int i = 0; i < N_FLOORS; i++) begin
      floor_oh[i] = (floor_q == FLOOR_W'(i));
      if (eff[i] && (FLOOR_W'(i) > floor_q)) ahead_up = 1'b1;
      if (eff[i] && (FLOOR_W'(i) < floor_q)) ahead_dn = 1'b1;
    end
    up_oh      = floor_oh << 1;
    dn_oh      = floor_oh >> 1;
    here_call  = |(eff & floor_oh);
    ahead_same = dir_q ? ahead_up : ahead_dn;
    ahead_back = dir_q ? ahead_dn : ahead_up;

    // Departure choice used when leaving IDLE or DOOR_OPEN: keep the current
    // direction if possible, otherwise reverse, otherwise park.
    depart_state = S_IDLE;
    depart_dir   = dir_q;
    if (ahead_same) begin
      depart_state = dir_q ? S_MOVE_UP : S_MOVE_DN;
    end else if (ahead_back) begin
      depart_state = dir_q ? S_MOVE_DN : S_MOVE_UP;
      depart_dir   = ~dir_q;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    floor_d    = floor_q;
    dir_d      = dir_q;
    timer_d    = timer_q;
    serve_mask = '0;
    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (here_call) begin
          state_d    = S_DOOR;
          serve_mask = floor_oh;
        end else begin
          state_d = depart_state;
          dir_d   = depart_dir;
        end
      end
      S_MOVE_UP: begin
        if (floor_q == TOP_FLOOR) begin
          // Cannot happen while a request lies ahead; park rather than overrun.
          state_d = S_IDLE;
          timer_d = '0;
        end else if (timer_q == MOVE_LAST) begin
          floor_d = floor_q + 1'b1;
          timer_d = '0;
          if (|(eff & up_oh)) begin
            state_d    = S_DOOR;
            serve_mask = up_oh;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_MOVE_DN: begin
        if (floor_q == '0) begin
          state_d = S_IDLE;
          timer_d = '0;
        end else if (timer_q == MOVE_LAST) begin
          floor_d = floor_q - 1'b1;
          timer_d = '0;
          if (|(eff & dn_oh)) begin
            state_d    = S_DOOR;
            serve_mask = dn_oh;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_DOOR: begin
        if (|(call_in & floor_oh)) begin
          // Someone pressed this floor again: absorb it and hold the door longer.
          timer_d    = '0;
          serve_mask = floor_oh;
        end else if (timer_q == DOOR_LAST) begin
          timer_d = '0;
          state_d = depart_state;
          dir_d   = depart_dir;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase
    pending_d = eff & ~serve_mask;
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q   <= S_IDLE;
      floor_q   <= '0;
      pending_q <= '0;
      dir_q     <= 1'b1;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      floor_q   <= floor_d;
      pending_q <= pending_d;
      dir_q     <= dir_d;
      timer_q   <= timer_d;
    end
  end

  assign current_floor = floor_q;
  assign pending       = pending_q;
  assign dir_up        = dir_q;
  assign door_open     = (state_q == S_DOOR);
  assign moving        = (state_q == S_MOVE_UP) || (state_q == S_MOVE_DN);
  assign idle          = (state_q == S_IDLE);

endmodule

// File: tb/tb_elevator_scan_controller.sv
// tb_elevator_scan_controller
//   Bench for elevator_scan_controller with default parameters (8 floors,
//   MOVE_TICKS=10, DOOR_TICKS=5). Each call pushes the expected door-open
//   event (floor, edge number, dwell length) onto a queue. A monitor pops an
//   entry whenever door_open rises and compares against it. A vector table
//   covers single calls; hand-written sequences cover the multi-cycle cases.
module tb_elevator_scan_controller;

  localparam int NF = 8;
  localparam int MT = 10;
  localparam int DT = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NF-1:0] call_in;
  logic [3:0]    current_floor;
  logic [NF-1:0] pending;
  logic          door_open;
  logic          moving;
  logic          dir_up;
  logic          idle;

  elevator_scan_controller #(
    .N_FLOORS(NF), .FLOOR_W(4), .MOVE_TICKS(MT), .DOOR_TICKS(DT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .call_in(call_in),
    .current_floor(current_floor), .pending(pending),
    .door_open(door_open), .moving(moving), .dir_up(dir_up), .idle(idle)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {int flr; int cyc; int dur;} door_ev_t;
  door_ev_t sb[$];

  // Door-open monitor
  logic     prev_door = 1'b0;
  logic     active    = 1'b0;
  int       run_len   = 0;
  int       dur_exp   = 0;
  logic     oob       = 1'b0;
  door_ev_t ev;

  always @(negedge clk) begin
    if (current_floor > 4'(NF - 1)) oob = 1'b1;
    if (door_open && !prev_door) begin
      if (sb.size() == 0) begin
        check("door_unexpected", 32'(current_floor), 32'hFFFF);
      end else begin
        ev = sb.pop_front();
        check("door_floor", 32'(current_floor), 32'(ev.flr));
        check("door_cycle", 32'(cyc), 32'(ev.cyc));
        dur_exp = ev.dur;
        active  = 1'b1;
      end
      run_len = 1;
    end else if (door_open) begin
      run_len++;
    end
    if (!door_open && prev_door && active) begin
      check("door_dwell", 32'(run_len), 32'(dur_exp));
      active = 1'b0;
    end
    prev_door = door_open;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int n);
    while (cyc < n) step();
  endtask

  task automatic issue(input logic [NF-1:0] m, output int c);
    c       = cyc;
    call_in = m;
    step();
    call_in = '0;
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (idle && sb.size() == 0 && !active) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check("wait_idle_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    step();
  endtask

  typedef struct {int flr; logic exp_moving; logic exp_dir;} vec_t;
  vec_t vecs[6];

  int            c, c2, car, d, e;
  logic [NF-1:0] m;

  initial begin : wdog
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{3, 1'b1, 1'b1};
    vecs[1] = '{3, 1'b0, 1'b1};
    vecs[2] = '{1, 1'b1, 1'b0};
    vecs[3] = '{7, 1'b1, 1'b1};
    vecs[4] = '{0, 1'b1, 1'b0};
    vecs[5] = '{4, 1'b1, 1'b1};

    // Reset with every call asserted: calls must be discarded.
    rst_n   = 1'b1;
    call_in = '1;
    #1;
    repeat (3) step();
    rst_n   = 1'b0;
    call_in = '0;
    check("rst_floor",   32'(current_floor), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_idle",    32'(idle), 32'd1);
    check("rst_dir",     32'(dir_up), 32'd1);
    check("rst_door",    32'(door_open), 32'd0);
    check("rst_moving",  32'(moving), 32'd0);
    step();
    check("post_rst_idle",    32'(idle), 32'd1);
    check("post_rst_pending", 32'(pending), 32'd0);
    car = 0;

    // Single calls from the table
    for (int v = 0; v < 6; v++) begin
      m = '0;
      m[vecs[v].flr] = 1'b1;
      issue(m, c);
      d = (vecs[v].flr > car) ? vecs[v].flr - car : car - vecs[v].flr;
      sb.push_back('{vecs[v].flr, c + 1 + d * MT, DT});
      @(negedge clk);
      check("vec_moving", 32'(moving), 32'(vecs[v].exp_moving));
      wait_idle();
      check("vec_floor",   32'(current_floor), 32'(vecs[v].flr));
      check("vec_dir",     32'(dir_up), 32'(vecs[v].exp_dir));
      check("vec_pending", 32'(pending), 32'd0);
      check("vec_idle",    32'(idle), 32'd1);
      car = vecs[v].flr;
    end

    // At 4 heading up to 6, floor 1 called mid-move: 6 first, then reverse to 1.
    issue(8'h40, c);
    sb.push_back('{6, c + 21, DT});
    sb.push_back('{1, c + 21 + DT + 5 * MT, DT});
    repeat (3) step();
    issue(8'h02, c2);
    @(negedge clk);
    check("scan_pending", 32'(pending), 32'h42);
    goto(c + 30);
    check("scan_rev_dir",    32'(dir_up), 32'd0);
    check("scan_rev_moving", 32'(moving), 32'd1);
    wait_idle();
    check("scan_floor", 32'(current_floor), 32'd1);
    check("scan_dir",   32'(dir_up), 32'd0);

    // Back to 0, then floors 5 and 2 called together: stop at 2, then at 5.
    issue(8'h01, c);
    sb.push_back('{0, c + 1 + MT, DT});
    wait_idle();
    issue(8'h24, c);
    sb.push_back('{2, c + 21, DT});
    sb.push_back('{5, c + 21 + DT + 3 * MT, DT});
    @(negedge clk);
    check("multi_pend0", 32'(pending), 32'h24);
    goto(c + 21);
    check("multi_pend1", 32'(pending), 32'h20);
    check("multi_door2", 32'(door_open), 32'd1);
    wait_idle();
    check("multi_pend2", 32'(pending), 32'd0);
    check("multi_floor", 32'(current_floor), 32'd5);

    // Door open at 2, same floor re-called on dwell cycle 3: the dwell restarts.
    issue(8'h04, c);
    e = c + 1 + 3 * MT;
    sb.push_back('{2, e, 9});
    goto(e + 3);
    call_in = 8'h04;
    step();
    call_in = '0;
    @(negedge clk);
    check("dwell_pending", 32'(pending), 32'd0);
    goto(e + 8);
    check("dwell_still_open", 32'(door_open), 32'd1);
    wait_idle();
    check("dwell_pend_end", 32'(pending), 32'd0);
    check("dwell_floor",    32'(current_floor), 32'd2);

    // Alternate top floor and floor 0, then reset mid-move.
    issue(8'h80, c);
    sb.push_back('{7, c + 1 + 5 * MT, DT});
    wait_idle();
    check("alt_top", 32'(current_floor), 32'd7);
    issue(8'h01, c);
    sb.push_back('{0, c + 1 + 7 * MT, DT});
    wait_idle();
    check("alt_bottom", 32'(current_floor), 32'd0);
    issue(8'h80, c);
    repeat (15) step();
    check("mid_move_floor",  32'(current_floor), 32'd1);
    check("mid_move_moving", 32'(moving), 32'd1);
    rst_n = 1'b1;
    step();
    rst_n = 1'b0;
    check("abort_floor",   32'(current_floor), 32'd0);
    check("abort_idle",    32'(idle), 32'd1);
    check("abort_pending", 32'(pending), 32'd0);
    check("abort_moving",  32'(moving), 32'd0);
    check("abort_dir",     32'(dir_up), 32'd1);
    repeat (3) step();
    check("abort_stay_idle", 32'(idle), 32'd1);

    check("sb_empty",    32'(sb.size()), 32'd0);
    check("floor_range", 32'(oob), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
